if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  from the hazard unit; 1 = the IF/ID register will not load this cycle.
REQ-005 redirect_valid  in  1  branch/jump taken; flushes the stage and restarts fetch.
REQ-006 redirect_pc  in  32  target address of the redirect.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  32  word-aligned fetch address.
REQ-009 imem_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_valid  in  1  response data is valid this cycle.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 if_valid  out  1  output slot holds an instruction; drives the IF/ID load.
REQ-013 if_pc  out  32  address of the instruction in the output slot.
REQ-014 if_instr  out  32  instruction in the output slot.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, WAIT and FULL; at most one request is outstanding.
REQ-016 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-017 REQ SHALL drive imem_req=1 and imem_addr=pc only when the output slot is free or being consumed (!if_valid || !stall); otherwise it drives imem_req=0.
REQ-018 Request accepted (imem_req && imem_ready): fetch_pc<=pc, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), state<=WAIT.
REQ-019 WAIT with imem_valid=1, no kill, and slot free or consumed: SHALL load if_instr<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, then go to REQ.
REQ-020 WAIT with imem_valid=1 and the slot occupied and stalled: SHALL park the data and fetch_pc in a 1-entry skid buffer and go to FULL.
REQ-021 FULL SHALL move the skid contents into the output slot in the first cycle that stall=0, then go to REQ.
REQ-022 Slot consumption: a cycle with if_valid=1 and stall=0 consumes the slot; if_valid SHALL drop to 0 unless it is refilled in the same cycle.
REQ-023 The minimum latency, with an imem_ready and imem_valid one cycle apart, SHALL be one instruction per 2 cycles; if_valid rises on the edge after imem_valid.
REQ-024 redirect_valid SHALL have priority over stall and over all other activity, and SHALL: set pc<={redirect_pc[31:2],2'b00}, set if_valid<=0, clear the skid buffer, and go to REQ.
REQ-025 A redirect while a request is outstanding (state WAIT, or REQ with imem_ready=1 in the same cycle) SHALL set kill, go to WAIT, and drop the matching response without changing if_valid.
REQ-026 The dropped response SHALL clear kill and go to REQ; a second redirect in that window only updates pc.
REQ-027 imem_valid outside WAIT SHALL be ignored.

Reset
REQ-028 On reset (overriding redirect and stall), the block SHALL set pc=RESET_PC, fetch_pc=0, if_valid=0, if_pc=0, if_instr=0, skid empty, kill=0, state=IDLE, and imem_req=0.
REQ-029 A reset asserted mid-transaction SHALL abandon the outstanding request; a later imem_valid is ignored per REQ-027.

Configuration
REQ-030 With IF_PERF_CNT_EN defined, the block SHALL add outputs perf_fetched[31:0] and perf_stall[31:0] and wrapping counters, both reset to 0:
- perf_fetched increments on each slot load.
- perf_stall increments on each cycle with if_valid && stall.
REQ-031 Without IF_PERF_CNT_EN, those ports and counters SHALL be absent, with identical functional behaviour.

Verification
REQ-032 Reset, RESET_PC=0, memory ready=1 with 1-cycle valid, stall=0 -> imem_addr sequence 0,4,8,...; if_pc/if_instr match; if_valid first rises 3 cycles after reset drops.
REQ-033 Slot full with if_pc=4, stall held 5 cycles, response for 8 arrives -> state FULL, if_pc remains 4; stall drops -> if_pc=8 next edge, then request for 12.
REQ-034 Redirect to 0x100 while WAIT for 0x10 -> the 0x10 response is dropped, if_valid=0, next imem_addr=0x100.
REQ-035 Redirect and stall together with if_valid=1 -> if_valid=0 next cycle, pc=redirect target.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second imem_addr=0; redirect_pc=0x103 -> imem_addr=0x100.
REQ-037 With IF_PERF_CNT_EN: 10 fetches and 3 stalled-full cycles -> perf_fetched=10, perf_stall=3.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage with one outstanding memory request,
// a single output slot feeding the IF/ID register and a 1-entry skid buffer.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   stall                IF/ID will not load this cycle
//   redirect_valid/_pc   taken branch/jump: flush and restart fetch at redirect_pc
//   imem_req/_addr       fetch request and word-aligned address
//   imem_ready           memory accepts the request this cycle
//   imem_valid/_rdata    response strobe and instruction word
//   if_valid/_pc/_instr  output slot contents
//   perf_fetched/_stall  slot-load and stalled-full-slot counters
//                        (present only when IF_PERF_CNT_EN is defined)
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, fetch_pc, fetch_pc_n;
   logic [31:0] if_pc_n, if_instr_n, skid_pc, skid_pc_n, skid_instr, skid_instr_n;
   logic if_valid_n, kill, kill_n, slot_free, accept, load;
   // the slot can take new data when empty or when IF/ID takes it this cycle
   assign slot_free = !if_valid || !stall;
   assign imem_req  = (state == REQ) && slot_free;
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         fetch_pc   <= 32'd0;
         if_valid   <= 1'b0;
         if_pc      <= 32'd0;
         if_instr   <= 32'd0;
         skid_pc    <= 32'd0;
         skid_instr <= 32'd0;
         kill       <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         fetch_pc   <= fetch_pc_n;
         if_valid   <= if_valid_n;
         if_pc      <= if_pc_n;
         if_instr   <= if_instr_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
         kill       <= kill_n;
      end
   end
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      fetch_pc_n   = fetch_pc;
      if_valid_n   = if_valid && stall;
      if_pc_n      = if_pc;
      if_instr_n   = if_instr;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
      kill_n       = kill;
      load         = 1'b0;
      if (redirect_valid) begin
         pc_n       = redirect_pc & ~32'd3;
         if_valid_n = 1'b0;
         // a request still in flight must have its response discarded;
         // a response arriving this very cycle is simply dropped here
         kill_n     = (state == WAIT && !imem_valid) || accept;
         state_n    = kill_n ? WAIT : REQ;
      end else begin
         case (state)
            IDLE: state_n = REQ;
            REQ: if (accept) begin
               fetch_pc_n = pc;
               pc_n       = pc + 32'd4;
               state_n    = WAIT;
            end
            WAIT: if (imem_valid) begin
               if (kill) begin
                  kill_n  = 1'b0;
                  state_n = REQ;
               end else if (slot_free) begin
                  load       = 1'b1;
                  if_pc_n    = fetch_pc;
                  if_instr_n = imem_rdata;
                  state_n    = REQ;
               end else begin
                  skid_pc_n    = fetch_pc;
                  skid_instr_n = imem_rdata;
                  state_n      = FULL;
               end
            end
            FULL: if (!stall) begin
               load       = 1'b1;
               if_pc_n    = skid_pc;
               if_instr_n = skid_instr;
               state_n    = REQ;
            end
            default: state_n = IDLE;
         endcase
      end
      if (load) if_valid_n = 1'b1;
   end
`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (load) perf_fetched <= perf_fetched + 32'd1;
         if (if_valid && stall) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized and directed bench for if_fetch_stage with a
// transaction-level scoreboard (expected fetch address, in-flight request,
// queue of instructions owed to IF/ID).
module tb_if_fetch_stage;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;
   logic        imem_req1, if_valid1;
   logic [31:0] imem_addr1, if_pc1, if_instr1;
   logic        imem_ready1 = 1'b1;
   logic        imem_valid1 = 1'b1;
   logic [31:0] imem_rdata1 = 32'hCAFE_0001;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_fetched1, perf_stall1;
`endif

   if_fetch_stage dut (
      .clock(clock), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
`ifdef IF_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clock(clock), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(imem_ready1),
      .imem_valid(imem_valid1), .imem_rdata(imem_rdata1),
      .if_valid(if_valid1), .if_pc(if_pc1), .if_instr(if_instr1)
`ifdef IF_PERF_CNT_EN
      , .perf_fetched(perf_fetched1), .perf_stall(perf_stall1)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [31:0] q[$];
   logic [31:0] d1_addrs[$];
   logic [31:0] m_pc, pend_addr, acc_addr;
   bit pend, pend_kill, acc_seen, req_seen, found;
   int dly, fixed_dly, m_fetched, m_stalls, cnt, n;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

`ifdef IF_PERF_CNT_EN
   task automatic check_perf();
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stalls);
   endtask
`endif

   // one clock cycle: check slot against the scoreboard, drive inputs, then
   // advance the model by what the coming edge must do
   task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit rdy);
      bit resp, acc;
      chk("slot_valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
      if (if_valid && q.size() != 0) begin
         chk("if_pc", if_pc, q[0]);
         chk("if_instr", if_instr, hash(q[0]));
      end
      stall = s;
      redirect_valid = r;
      redirect_pc = rpc;
      imem_ready = rdy;
      resp = pend && dly == 0;
      imem_valid = resp || (!pend && $urandom_range(2) == 0);
      imem_rdata = resp ? hash(pend_addr) : $urandom;
      #1;
      acc = imem_req && imem_ready;
      chk("one_outstanding", {31'b0, imem_req && pend}, 32'd0);
      if (imem_req1) d1_addrs.push_back(imem_addr1);
      if (acc) chk("imem_addr", imem_addr, m_pc);
      acc_seen = acc;
      acc_addr = imem_addr;
      req_seen = imem_req;
      if (q.size() != 0 && s) m_stalls++;
      if (q.size() != 0 && !s) begin
         q.delete(0);
         if (q.size() != 0 && !r) m_fetched++;
      end
      if (resp) begin
         pend = 0;
         if (!pend_kill && !r) begin
            if (q.size() == 0) m_fetched++;
            q.push_back(pend_addr);
         end
      end else if (pend) dly--;
      if (r) begin
         q.delete();
         if (pend) pend_kill = 1;
      end
      if (acc) begin
         pend = 1;
         pend_addr = m_pc;
         pend_kill = r;
         dly = fixed_dly >= 0 ? fixed_dly : $urandom_range(2);
      end
      m_pc = r ? (rpc & ~32'd3) : (acc ? m_pc + 32'd4 : m_pc);
      @(negedge clock);
   endtask

   task automatic rand_step();
      step($urandom_range(2) == 0, $urandom_range(15) == 0, $urandom, $urandom_range(1) == 1);
   endtask

   task automatic do_reset();
      reset = 1;
      stall = 0;
      redirect_valid = 0;
      imem_ready = 0;
      imem_valid = 1;
      imem_rdata = $urandom;
      repeat (2) @(negedge clock);
      reset = 0;
      q.delete();
      d1_addrs.delete();
      pend = 0;
      pend_kill = 0;
      dly = 0;
      m_pc = 32'd0;
      m_fetched = 0;
      m_stalls = 0;
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
      check_perf();
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      fixed_dly = 0;
      @(negedge clock);
      do_reset();
      // back-to-back fetch, first slot load three edges after reset release
      cnt = 0;
      found = 0;
      while (!found && cnt < 10) begin
         step(0, 0, 0, 1);
         cnt++;
         found = if_valid;
      end
      chk("first_valid_latency", cnt, 3);
      n = 0;
      repeat (8) begin
         step(0, 0, 0, 1);
         n += int'(acc_seen);
      end
      chk("two_cycle_rate", n, 4);
      chk("wrap_count", {31'b0, d1_addrs.size() >= 2}, 32'd1);
      if (d1_addrs.size() >= 2) begin
         chk("wrap_first", d1_addrs[0], 32'hFFFF_FFFC);
         chk("wrap_second", d1_addrs[1], 32'd0);
      end
      // held slot under stall, then resume
      do_reset();
      cnt = 0;
      while (!(if_valid && if_pc == 32'd4) && cnt < 10) begin
         step(0, 0, 0, 1);
         cnt++;
      end
      chk("reach_pc4", {31'b0, if_valid && if_pc == 32'd4}, 32'd1);
      repeat (5) begin
         step(1, 0, 0, 1);
         chk("stall_no_req", {31'b0, req_seen}, 32'd0);
         chk("stall_hold_pc", if_pc, 32'd4);
      end
      step(0, 0, 0, 1);
      chk("resume_acc", {31'b0, acc_seen}, 32'd1);
      chk("resume_addr", acc_addr, 32'd8);
      step(0, 0, 0, 1);
      chk("resume_pc8", if_pc, 32'd8);
      step(0, 0, 0, 1);
      chk("next_acc", {31'b0, acc_seen}, 32'd1);
      chk("next_addr12", acc_addr, 32'd12);
      // redirect while waiting on 0x10
      do_reset();
      fixed_dly = 2;
      cnt = 0;
      found = 0;
      while (!found && cnt < 40) begin
         step(0, 0, 0, 1);
         cnt++;
         found = acc_seen && acc_addr == 32'h10;
      end
      chk("reach_req10", {31'b0, found}, 32'd1);
      step(0, 1, 32'h100, 1);
      cnt = 0;
      found = 0;
      while (!found && cnt < 10) begin
         chk("kill_no_valid", {31'b0, if_valid}, 32'd0);
         step(0, 0, 0, 1);
         cnt++;
         found = acc_seen;
      end
      chk("redirect_addr", acc_addr, 32'h100);
      // redirect together with stall on a full slot, unaligned target
      fixed_dly = 0;
      do_reset();
      cnt = 0;
      while (!if_valid && cnt < 10) begin
         step(0, 0, 0, 1);
         cnt++;
      end
      step(1, 1, 32'h103, 1);
      chk("redir_stall_valid", {31'b0, if_valid}, 32'd0);
      cnt = 0;
      found = 0;
      while (!found && cnt < 10) begin
         step(0, 0, 0, 1);
         cnt++;
         found = acc_seen;
      end
      chk("redir_aligned_addr", acc_addr, 32'h100);
`ifdef IF_PERF_CNT_EN
      do_reset();
      cnt = 0;
      while (m_fetched < 10 && cnt < 60) begin
         step(0, 0, 0, 1);
         cnt++;
      end
      repeat (3) step(1, 0, 0, 1);
      chk("perf_ten", perf_fetched, 32'd10);
      chk("perf_three", perf_stall, 32'd3);
`endif
      // random traffic, a reset in the middle of it, more traffic
      fixed_dly = -1;
      repeat (3000) rand_step();
`ifdef IF_PERF_CNT_EN
      check_perf();
`endif
      do_reset();
      repeat (500) rand_step();
`ifdef IF_PERF_CNT_EN
      check_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
